// File: rtl/pipe_share_arbiter_pkg.sv
// Shared helpers for the pipelined-datapath sharing arbiter: width derivations
// for requester IDs and per-requester credit counters.
package pipe_share_arbiter_pkg;

   // Upper bound on the requester count; IDs therefore never exceed 4 bits.
   localparam int unsigned MAX_NUM_REQ = 16;

   // Ceiling log2, floored at 1 so that a degenerate count still gets a real bit.
   function automatic int clog2_min1(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return (w < 1) ? 1 : w;
   endfunction

   // Width of a requester index.
   function automatic int id_width(input int num_req);
      return clog2_min1(num_req);
   endfunction

   // Width of a credit counter that must hold 0..max_out inclusive.
   function automatic int credit_width(input int max_out);
      return clog2_min1(max_out + 1);
   endfunction

endpackage

// File: rtl/pipe_share_arbiter_tag_delay.sv
// Delay line carrying the {valid, ID} tag alongside the shared datapath so the
// tag emerges in the same cycle as the matching result. Reset clears every stage,
// which is what drops results still in flight when the block is reset.
module pipe_tag_delay
   import pipe_share_arbiter_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int ID_W    = 2
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            in_valid_i,
   input  logic [ID_W-1:0] in_id_i,
   output logic            out_valid_o,
   output logic [ID_W-1:0] out_id_o,
   output logic            any_valid_o
);

   // Bit ID_W is the valid flag, the low bits are the requester ID.
   logic [ID_W:0] stage_q [LATENCY];

   // Shift the tag one stage per cycle; synchronous clear on reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int k = 0; k < LATENCY; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         stage_q[0] <= {in_valid_i, in_id_i};
         for (int k = 1; k < LATENCY; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   assign out_valid_o = stage_q[LATENCY-1][ID_W];
   assign out_id_o    = stage_q[LATENCY-1][ID_W-1:0];

   // Any stage holding a live tag keeps the block busy.
   always_comb begin
      any_valid_o = 1'b0;
      for (int k = 0; k < LATENCY; k++) begin
         any_valid_o = any_valid_o | stage_q[k][ID_W];
      end
   end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency datapath among NUM_REQ
// requesters. One operand is issued per cycle; the winner's ID rides a tag
// delay line so each result is steered back to its owner. Per-requester credit
// counters cap the number of operations each requester has in flight.
module pipe_share_arbiter
   import pipe_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int PIPE_LATENCY    = 3,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic [NUM_REQ-1:0]              REQ,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_DATA,
   output logic [NUM_REQ-1:0]              GNT,
   output logic                            DP_IN_VALID,
   output logic [DATA_WIDTH-1:0]           DP_IN_DATA,
   input  logic [DATA_WIDTH-1:0]           DP_OUT_DATA,
   output logic [NUM_REQ-1:0]              RSP_VALID,
   output logic [DATA_WIDTH-1:0]           RSP_DATA,
   output logic                            BUSY
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = credit_width(MAX_OUTSTANDING);

   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    out_nz;
   logic [NUM_REQ-1:0]    gnt_d;
   logic                  gnt_any;
   logic [ID_W-1:0]       win_id;
   logic [DATA_WIDTH-1:0] win_data;
   logic [ID_W-1:0]       ptr_q;
   logic [ID_W-1:0]       ptr_d;
   logic [NUM_REQ-1:0]    rsp_dec;

   logic                  dp_in_valid_q;
   logic [DATA_WIDTH-1:0] dp_in_data_q;
   logic [ID_W-1:0]       dp_in_id_q;
   logic [NUM_REQ-1:0]    rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic [CNT_W-1:0]      out_q [NUM_REQ];

   logic                  tag_out_valid;
   logic [ID_W-1:0]       tag_out_id;
   logic                  tag_any_valid;

   // A requester may compete only while it still has a free credit.
   always_comb begin
      eligible = '0;
      out_nz   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = REQ[i] && (out_q[i] < CNT_W'(MAX_OUTSTANDING));
         out_nz[i]   = (out_q[i] != '0);
      end
   end

   // Round-robin pick: scan from the pointer upward, then wrap to the bottom.
   always_comb begin
      gnt_d    = '0;
      gnt_any  = 1'b0;
      win_id   = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && eligible[i] && (ID_W'(i) >= ptr_q)) begin
            gnt_any  = 1'b1;
            gnt_d[i] = 1'b1;
            win_id   = ID_W'(i);
            win_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && eligible[i] && (ID_W'(i) < ptr_q)) begin
            gnt_any  = 1'b1;
            gnt_d[i] = 1'b1;
            win_id   = ID_W'(i);
            win_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (RESET) begin
         gnt_d   = '0;
         gnt_any = 1'b0;
      end
   end

   // Pointer moves just past the winner; it stays put on an idle cycle.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         ptr_d = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
      end
   end

   // One-hot decode of the tag emerging from the delay line.
   always_comb begin
      rsp_dec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_dec[i] = tag_out_valid && (tag_out_id == ID_W'(i));
      end
   end

   // Issue register, pointer and response register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ptr_q         <= '0;
         dp_in_valid_q <= 1'b0;
         dp_in_data_q  <= '0;
         dp_in_id_q    <= '0;
         rsp_valid_q   <= '0;
         rsp_data_q    <= '0;
      end else begin
         ptr_q         <= ptr_d;
         dp_in_valid_q <= gnt_any;
         if (gnt_any) begin
            dp_in_data_q <= win_data;
            dp_in_id_q   <= win_id;
         end
         rsp_valid_q <= rsp_dec;
         if (tag_out_valid) begin
            rsp_data_q <= DP_OUT_DATA;
         end
      end
   end

   // Credit counters: +1 on grant, -1 as the response registers; both cancel.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (RESET) begin
            out_q[i] <= '0;
         end else if (gnt_d[i] && !rsp_dec[i]) begin
            out_q[i] <= out_q[i] + 1'b1;
         end else if (!gnt_d[i] && rsp_dec[i]) begin
            out_q[i] <= out_q[i] - 1'b1;
         end
      end
   end

   pipe_tag_delay #(
      .LATENCY (PIPE_LATENCY),
      .ID_W    (ID_W)
   ) u_tag_delay (
      .CLK         (CLK),
      .RESET       (RESET),
      .in_valid_i  (dp_in_valid_q),
      .in_id_i     (dp_in_id_q),
      .out_valid_o (tag_out_valid),
      .out_id_o    (tag_out_id),
      .any_valid_o (tag_any_valid)
   );

   assign GNT         = gnt_d;
   assign DP_IN_VALID = dp_in_valid_q;
   assign DP_IN_DATA  = dp_in_data_q;
   assign RSP_VALID   = rsp_valid_q;
   assign RSP_DATA    = rsp_data_q;
   assign BUSY        = dp_in_valid_q | tag_any_valid | (|rsp_valid_q) | (|out_nz);

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter with an identity-delay datapath model.
// Stimulus pushes expected responses into a queue; a monitor pops and compares.
module tb_pipe_share_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int L  = 3;
   localparam int MO = 2;

   logic           CLK;
   logic           RESET;
   logic [NR-1:0]  REQ;
   logic [NR*DW-1:0] REQ_DATA;
   logic [NR-1:0]  GNT;
   logic           DP_IN_VALID;
   logic [DW-1:0]  DP_IN_DATA;
   logic [DW-1:0]  DP_OUT_DATA;
   logic [NR-1:0]  RSP_VALID;
   logic [DW-1:0]  RSP_DATA;
   logic           BUSY;

   pipe_share_arbiter #(
      .NUM_REQ         (NR),
      .DATA_WIDTH      (DW),
      .PIPE_LATENCY    (L),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .REQ         (REQ),
      .REQ_DATA    (REQ_DATA),
      .GNT         (GNT),
      .DP_IN_VALID (DP_IN_VALID),
      .DP_IN_DATA  (DP_IN_DATA),
      .DP_OUT_DATA (DP_OUT_DATA),
      .RSP_VALID   (RSP_VALID),
      .RSP_DATA    (RSP_DATA),
      .BUSY        (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Identity datapath: L register stages.
   logic [DW-1:0] dp_pipe [L];
   always @(posedge CLK) begin
      dp_pipe[0] <= DP_IN_DATA;
      for (int k = 1; k < L; k++) dp_pipe[k] <= dp_pipe[k-1];
   end
   assign DP_OUT_DATA = dp_pipe[L-1];

   typedef struct {
      int            cyc;
      logic [NR-1:0] oh;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [NR-1:0] oh, input logic [DW-1:0] d);
      exp_t e;
      e.cyc  = c;
      e.oh   = oh;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic set_data(input int i, input logic [DW-1:0] v);
      REQ_DATA[i*DW +: DW] = v;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1;
      REQ   = '0;
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   // Monitor: every response the DUT presents must match the head of the queue.
   always @(negedge CLK) begin
      if (RSP_VALID !== '0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual=%0h required=none (cycle %0d)", RSP_VALID, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
            chk("rsp_valid", 64'(RSP_VALID), 64'(mon_e.oh));
            chk("rsp_data", 64'(RSP_DATA), 64'(mon_e.data));
         end
      end
   end

   logic [7:0]    credit_pat;
   logic [NR-1:0] bp_req [5];
   logic [NR-1:0] bp_gnt [5];
   int            bp_win [5];

   initial begin
      RESET    = 1'b1;
      REQ      = '0;
      REQ_DATA = '0;
      credit_pat = 8'b0110_0011;
      bp_req = '{4'b0100, 4'b0100, 4'b0010, 4'b0101, 4'b0011};
      bp_gnt = '{4'b0100, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      bp_win = '{2, 2, 1, 0, 1};

      // Reset state, with requests asserted to show GNT is suppressed.
      repeat (2) @(negedge CLK);
      REQ = 4'hF;
      #1;
      chk("rst_gnt", 64'(GNT), 64'h0);
      chk("rst_dp_in_valid", 64'(DP_IN_VALID), 64'h0);
      chk("rst_dp_in_data", 64'(DP_IN_DATA), 64'h0);
      chk("rst_rsp_valid", 64'(RSP_VALID), 64'h0);
      chk("rst_rsp_data", 64'(RSP_DATA), 64'h0);
      chk("rst_busy", 64'(BUSY), 64'h0);
      @(negedge CLK);
      RESET = 1'b0;
      REQ   = '0;

      // Single requester: grant at t, issue at t+1, response at t+5.
      REQ = 4'b0010;
      set_data(1, 32'h0000_00A5);
      #1;
      chk("single_gnt", 64'(GNT), 64'h2);
      push(cyc + 5, 4'b0010, 32'h0000_00A5);
      @(negedge CLK);
      REQ = '0;
      #1;
      chk("single_dp_valid", 64'(DP_IN_VALID), 64'h1);
      chk("single_dp_data", 64'(DP_IN_DATA), 64'hA5);
      chk("single_gnt_idle", 64'(GNT), 64'h0);
      chk("single_busy", 64'(BUSY), 64'h1);
      repeat (5) @(negedge CLK);
      #1;
      chk("single_busy_done", 64'(BUSY), 64'h0);

      // Fairness: all four requesting for 8 cycles from reset.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         REQ = 4'hF;
         for (int i = 0; i < NR; i++) set_data(i, 32'h2000_0000 + 32'(i * 256 + k));
         #1;
         chk("fair_gnt", 64'(GNT), 64'(4'b0001 << (k % 4)));
         push(cyc + 5, 4'b0001 << (k % 4), 32'h2000_0000 + 32'((k % 4) * 256 + k));
         @(negedge CLK);
      end
      REQ = '0;
      repeat (8) @(negedge CLK);

      // Credit limit (2): grants at 0,1, stall 2..4, grants at 5,6, stall at 7.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         REQ = 4'b0001;
         set_data(0, 32'h3000 + 32'(k));
         #1;
         chk("credit_gnt", 64'(GNT), credit_pat[k] ? 64'h1 : 64'h0);
         if (credit_pat[k]) push(cyc + 5, 4'b0001, 32'h3000 + 32'(k));
         @(negedge CLK);
      end
      REQ = '0;
      repeat (8) @(negedge CLK);

      // Blocked pointer: requester 2 at its limit, pointer at 2, REQ=0101.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         REQ = bp_req[k];
         for (int i = 0; i < NR; i++) set_data(i, 32'h4000_0000 + 32'(k * 16 + i));
         #1;
         chk("blocked_gnt", 64'(GNT), 64'(bp_gnt[k]));
         push(cyc + 5, bp_gnt[k], 32'h4000_0000 + 32'(k * 16 + bp_win[k]));
         @(negedge CLK);
      end
      REQ = '0;
      repeat (8) @(negedge CLK);

      // Reset mid-flight: three issues, then reset; nothing may come back.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         REQ = 4'b0111;
         for (int i = 0; i < NR; i++) set_data(i, 32'h5000 + 32'(k * 16 + i));
         #1;
         chk("midrst_gnt", 64'(GNT), 64'(4'b0001 << k));
         @(negedge CLK);
      end
      RESET = 1'b1;
      REQ   = 4'hF;
      #1;
      chk("midrst_gnt_in_reset", 64'(GNT), 64'h0);
      @(negedge CLK);
      RESET = 1'b0;
      REQ   = '0;
      #1;
      chk("midrst_busy", 64'(BUSY), 64'h0);
      REQ = 4'hF;
      for (int i = 0; i < NR; i++) set_data(i, 32'h5555_0000 + 32'(i));
      #1;
      chk("midrst_first_gnt", 64'(GNT), 64'h1);
      push(cyc + 5, 4'b0001, 32'h5555_0000);
      @(negedge CLK);
      REQ = '0;
      repeat (10) @(negedge CLK);

      #1;
      chk("sb_drain", 64'(sb.size()), 64'h0);
      chk("final_busy", 64'(BUSY), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_share_arbiter.md
Name: pipe_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fixed-latency pipelined datapath among NUM_REQ requesters.
- The datapath is a chain of delay registers, or logic of equal latency.
- The block issues at most one operand per cycle into the datapath and carries the winner's ID and valid down a matching tag delay line. It steers each result back to its originating requester.
- Per-requester credit counters bound the number of in-flight operations.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..16.
- DATA_WIDTH, 32, operand and result width.
- PIPE_LATENCY, 3, cycles from DP_IN_VALID/DP_IN_DATA to the matching DP_OUT_DATA; must be at least 1.
- MAX_OUTSTANDING, 4, maximum in-flight operations per requester; must be at least 1.
- ID_W, clog2(NUM_REQ), requester index width; derived, not overridable.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- REQ  in  NUM_REQ  per-requester request; level held until granted
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  operand; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- GNT  out  NUM_REQ  one-hot or zero; combinational from REQ, credits and pointer; transfer occurs when REQ[i]&GNT[i]
- DP_IN_VALID  out  1  registered; operand valid into the datapath
- DP_IN_DATA  out  DATA_WIDTH  registered; operand of the winner
- DP_OUT_DATA  in  DATA_WIDTH  datapath result, valid PIPE_LATENCY cycles after the matching DP_IN_VALID
- RSP_VALID  out  NUM_REQ  registered one-hot; result for requester i
- RSP_DATA  out  DATA_WIDTH  registered result
- BUSY  out  1  high while any operation is in flight or issued

Behaviour:
- Reset values:
  - GNT=0 while RESET is high.
  - DP_IN_VALID=0, DP_IN_DATA=0.
  - RSP_VALID=0, RSP_DATA=0.
  - All credit counters 0, RR pointer 0, tag line cleared, BUSY=0.
- Eligibility: requester i is eligible when REQ[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- Arbitration:
  - Round-robin, starting at the pointer and wrapping modulo NUM_REQ.
  - After a grant to requester i, the pointer becomes (i+1) mod NUM_REQ.
  - The pointer is unchanged when nothing is granted.
  - At most one grant per cycle.
- Issue: a grant in cycle t produces DP_IN_VALID=1 and DP_IN_DATA=REQ_DATA[winner] in cycle t+1.
- Tag line:
  - {valid, ID} enters a PIPE_LATENCY-stage delay aligned with DP_IN_VALID.
  - Its output is valid in the same cycle as DP_OUT_DATA.
- Response:
  - When the tag output is valid, RSP_VALID[ID]=1 and RSP_DATA=DP_OUT_DATA in the next cycle.
  - Total latency is grant cycle t -> RSP at t+PIPE_LATENCY+2.
  - No backpressure: the requester must accept.
- Credits:
  - outstanding[i] increments on grant to i and decrements when the response to i is registered.
  - A simultaneous increment and decrement leaves the count unchanged.
  - The counter width holds 0..MAX_OUTSTANDING; it never wraps.
- When a requester hits MAX_OUTSTANDING, it is skipped by the arbiter.
  - Other eligible requesters win, even if the pointer points at the blocked requester.
- BUSY = DP_IN_VALID | any tag-line stage valid | any RSP_VALID | any outstanding ≠ 0.
- Issue back-to-back from one requester is allowed when it is the only eligible requester, giving a grant every cycle.
- Reset mid-operation:
  - Tags, credits and the pointer clear.
  - Results still emerging from the datapath are dropped: RSP_VALID stays 0 because tags are invalid.
- DP_IN_DATA holds its last value when DP_IN_VALID=0. Verification must not check DP_IN_DATA when DP_IN_VALID is low.

Decomposition:
- Shared package:
  - ID_W derivation function (clog2).
  - Credit-counter width function clog2(MAX_OUTSTANDING+1).
- Sub-module: pipe_tag_delay, a PIPE_LATENCY-stage, reset-clearing delay line of width 1+ID_W for the {valid, ID} tag.
- RR arbiter logic and credit counters stay inline.

Test Plan:
- Single requester:
  - Stimulus: REQ=4'b0010 for one cycle, REQ_DATA[1]=0xA5, PIPE_LATENCY=3, datapath identity delay.
  - Required: GNT=4'b0010 at t; DP_IN_VALID at t+1; RSP_VALID=4'b0010 with RSP_DATA=0xA5 at t+5.
- Fairness:
  - Stimulus: REQ=4'b1111 held for 8 cycles from reset.
  - Required: grant order 0,1,2,3,0,1,2,3; each RSP_VALID pulses twice in the same order.
- Credit limit:
  - Stimulus: MAX_OUTSTANDING=2, PIPE_LATENCY=3, REQ=4'b0001 held.
  - Required: grants at t and t+1, none at t+2..t+4, next grant at t+5 when the first response frees a credit; outstanding[0] never exceeds 2.
- Blocked pointer:
  - Stimulus: requester 2 at credit limit with pointer=2, REQ=4'b0101.
  - Required: GNT=4'b0001, and the pointer advances to 1.
- Reset mid-flight:
  - Stimulus: three issues in flight, then RESET high for 1 cycle.
  - Required: no RSP_VALID afterwards, BUSY=0 the cycle after reset, and the next grant comes from requester 0 priority.
